// File: rtl/data_router_ctrl.sv
// Row-reload command sequencer in front of the data router: waits for block-end, reloads each kernel row, then streams KSIZE column taps.
// Optional stall counter output enabled by defining DATA_ROUTER_CTRL_STALL_CNT_EN.
module data_router_ctrl #(
  parameter int POY    = 3,
  parameter int BUFH   = 3,
  parameter int BUFW   = 32,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int NBLKW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBLKW-1:0] num_blk,
  input  logic             blkend,
  output logic [1:0]       bank,
  output logic [1:0]       row,
  output logic [27:0]      col,
  output logic [1:0]       rpsel,
  output logic             tap_valid,
  input  logic             tap_ready,
  output logic [1:0]       tap_kr,
  output logic [1:0]       tap_kc,
  output logic [27:0]      tap_base,
  output logic             busy,
  output logic             done,
  output logic             blk_ovf
`ifdef DATA_ROUTER_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_TAP  = 2'd3;
  localparam logic [1:0] RR     = 2'b00;
  localparam logic [1:0] KLAST  = 2'(KSIZE - 1);
  localparam longint TAP_SPAN   = longint'(KSIZE - 1) + longint'(STRIDE) * longint'(BUFW - 1);

  // Downstream per-PE column arithmetic must stay inside the 28-bit column field.
  if (BUFH < KSIZE || POY < 1 || KSIZE > 4 || TAP_SPAN >= (longint'(1) << 28)) begin : g_cfg_err
    $error("data_router_ctrl: illegal configuration");
  end

  logic [1:0]       r_state;
  logic [1:0]       r_row;
  logic [1:0]       r_kr;
  logic [1:0]       r_kc;
  logic             r_tap_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_blk_ovf;
  logic             r_pending;
  logic [NBLKW-1:0] r_num_blk;
  logic [NBLKW-1:0] r_blk_cnt;
  logic [NBLKW-1:0] w_blk_cnt_nxt;
  logic             w_hs;

  assign w_hs          = r_tap_valid && tap_ready;
  assign w_blk_cnt_nxt = r_blk_cnt + NBLKW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= 2'd0;
      r_kr        <= 2'd0;
      r_kc        <= 2'd0;
      r_tap_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blk_ovf   <= 1'b0;
      r_pending   <= 1'b0;
      r_num_blk   <= '0;
      r_blk_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_blk <= (num_blk == '0) ? NBLKW'(1) : num_blk;
            r_blk_cnt <= '0;
            r_kr      <= 2'd0;
            r_kc      <= 2'd0;
            r_blk_ovf <= 1'b0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (blkend || r_pending) begin
            // A fresh blkend arriving while a pending one is consumed stays queued.
            r_pending <= r_pending && blkend;
            r_row     <= r_kr;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tap_valid <= 1'b1;
          r_state     <= S_TAP;
        end
        default: begin
          if (w_hs) begin
            if (r_kc != KLAST) begin
              r_kc <= r_kc + 2'd1;
            end else if (r_kr != KLAST) begin
              r_kr        <= r_kr + 2'd1;
              r_kc        <= 2'd0;
              r_row       <= r_kr + 2'd1;
              r_tap_valid <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_kr        <= 2'd0;
              r_kc        <= 2'd0;
              r_tap_valid <= 1'b0;
              r_blk_cnt   <= w_blk_cnt_nxt;
              if (w_blk_cnt_nxt == r_num_blk) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
        end
      endcase
      // Block-end arriving while a block is being walked is remembered one deep.
      if (blkend && (r_state == S_LOAD || r_state == S_TAP)) begin
        if (r_pending) r_blk_ovf <= 1'b1;
        else           r_pending <= 1'b1;
      end
    end
  end

`ifdef DATA_ROUTER_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (r_state == S_IDLE && start) begin
      r_stall_cnt <= 16'd0;
    end else if (r_tap_valid && !tap_ready && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bank      = 2'b00;
  assign col       = 28'd0;
  assign rpsel     = RR;
  assign row       = r_row;
  assign tap_valid = r_tap_valid;
  assign tap_kr    = r_kr;
  assign tap_kc    = r_kc;
  assign tap_base  = {26'd0, r_kc};
  assign busy      = r_busy;
  assign done      = r_done;
  assign blk_ovf   = r_blk_ovf;

endmodule

// File: tb/tb_data_router_ctrl.sv
// Self-checking bench for data_router_ctrl: vector table of pass lengths, a tap scoreboard, and hand-written corner sequences.
module tb_data_router_ctrl;
  localparam int KSIZE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_blk = 16'd1;
  logic        blkend = 1'b0;
  logic        tap_ready = 1'b1;
  logic [1:0]  bank, row, rpsel, tap_kr, tap_kc;
  logic [27:0] col, tap_base;
  logic        tap_valid, busy, done, blk_ovf;
`ifdef DATA_ROUTER_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] nb;
    int          blocks;
    int          done_cyc;
  } vec_t;
  vec_t tbl[4];

  data_router_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_blk(num_blk), .blkend(blkend),
    .bank(bank), .row(row), .col(col), .rpsel(rpsel),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_kr(tap_kr), .tap_kc(tap_kc),
    .tap_base(tap_base), .busy(busy), .done(done), .blk_ovf(blk_ovf)
`ifdef DATA_ROUTER_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_blocks(input int n);
    for (int b = 0; b < n; b++)
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++)
          exp_q.push_back({2'(r), 2'(c)});
  endtask

  task automatic wait_tap(input logic [1:0] r, input logic [1:0] c, input int bound);
    int n = 0;
    while (!(tap_valid && tap_kr == r && tap_kc == c) && n < bound) begin
      tick();
      n++;
    end
    chk("wait_tap_in_time", 32'(n < bound), 32'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("wait_done_in_time", 32'(n < bound), 32'd1);
  endtask

  task automatic begin_pass(input logic [15:0] nb, input int blocks);
    num_blk = nb;
    start = 1'b1;
    base = cyc;
    push_blocks(blocks);
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_blkend();
    blkend = 1'b1;
    tick();
    blkend = 1'b0;
  endtask

  task automatic chk_stable_11();
    chk("bp_valid", 32'(tap_valid), 32'd1);
    chk("bp_tap", {30'd0, tap_kr, tap_kc} & 32'hF, 32'h5);
    chk("bp_row", 32'(row), 32'd1);
  endtask

  // Scoreboard: each accepted tap must be the next expected (kr,kc).
  always @(negedge clk) begin
    if (!rst && tap_valid && tap_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tap actual=%0d,%0d required=none", tap_kr, tap_kc);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("tap_order", {28'd0, tap_kr, tap_kc}, {28'd0, e});
        chk("tap_base", tap_base, {30'd0, e[1:0]});
        chk("tap_row", 32'(row), {30'd0, e[3:2]});
        chk("cmd_const", {bank, rpsel, col}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int left;
    int n;
    tbl[0] = '{nb: 16'd1, blocks: 1, done_cyc: 14};
    tbl[1] = '{nb: 16'd0, blocks: 1, done_cyc: 14};
    tbl[2] = '{nb: 16'd2, blocks: 2, done_cyc: 27};
    tbl[3] = '{nb: 16'd3, blocks: 3, done_cyc: 40};

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(tap_valid), 32'd0);
    chk("rst_row_kr_kc", {26'd0, row, tap_kr, tap_kc}, 32'd0);
    chk("rst_cmd", {bank, rpsel, col}, 32'd0);
    chk("rst_ovf", 32'(blk_ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Single block, full throughput, exact cycle positions.
    begin_pass(16'd1, 1);
    chk("s1_busy", 32'(busy), 32'd1);
    while (cyc - base < 5) tick();
    pulse_blkend();
    chk("s1_load0_row", 32'(row), 32'd0);
    chk("s1_load0_valid", 32'(tap_valid), 32'd0);
    tick();
    chk("s1_first_valid", 32'(tap_valid), 32'd1);
    chk("s1_first_tap", {28'd0, tap_kr, tap_kc}, 32'd0);
    while (cyc - base < 10) tick();
    chk("s1_load1", {30'd0, tap_valid, row[0]} | {29'd0, row[1], 2'b00}, 32'd1);
    while (cyc - base < 14) tick();
    chk("s1_load2_row", 32'(row), 32'd2);
    chk("s1_load2_valid", 32'(tap_valid), 32'd0);
    while (cyc - base < 18) tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy_low", 32'(busy), 32'd0);
    tick();
    chk("s1_done_pulse", 32'(done), 32'd0);
    chk("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Pass-length table; blkend for the next block arrives with the last tap.
    for (int i = 0; i < 4; i++) begin
      begin_pass(tbl[i].nb, tbl[i].blocks);
      pulse_blkend();
      left = tbl[i].blocks - 1;
      n = 0;
      while (!done && n < 200) begin
        blkend = 1'b0;
        if (tap_valid && tap_ready && tap_kr == 2'd2 && tap_kc == 2'd2 && left > 0) begin
          blkend = 1'b1;
          left--;
        end
        tick();
        n++;
      end
      blkend = 1'b0;
      chk("tbl_done_cycle", 32'(cyc - base), 32'(tbl[i].done_cyc));
      chk("tbl_busy_low", 32'(busy), 32'd0);
      chk("tbl_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();
      chk("tbl_done_once", 32'(done), 32'd0);
    end

    // Backpressure at (1,1) for 4 cycles and at (2,0) for 3 cycles.
    begin_pass(16'd1, 1);
    pulse_blkend();
    wait_tap(2'd1, 2'd1, 20);
    tap_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_stable_11();
    end
    tick();
    tap_ready = 1'b1;
    chk_stable_11();
    wait_tap(2'd2, 2'd0, 20);
    tap_ready = 1'b0;
    tick();
    chk("bp2_tap", {28'd0, tap_kr, tap_kc}, 32'h8);
    tick();
    chk("bp2_valid", 32'(tap_valid), 32'd1);
    tick();
    tap_ready = 1'b1;
    wait_done(40);
    tick();
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef DATA_ROUTER_CTRL_STALL_CNT_EN
    chk("stall_cnt_7", 32'(stall_cnt), 32'd7);
    begin_pass(16'd1, 1);
    chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
    pulse_blkend();
    wait_done(40);
    tick();
`endif

    // Mid-TAP blkend sets pending; block 1 starts right after WAIT is entered.
    begin_pass(16'd2, 2);
    pulse_blkend();
    wait_tap(2'd1, 2'd0, 20);
    pulse_blkend();
    wait_done(60);
    chk("pend_done_cycle", 32'(cyc - base), 32'd27);
    chk("pend_no_ovf", 32'(blk_ovf), 32'd0);
    tick();
    chk("pend_done_once", 32'(done), 32'd0);

    // Two blkends in one TAP phase overflow the pending flag.
    begin_pass(16'd2, 2);
    pulse_blkend();
    wait_tap(2'd0, 2'd1, 20);
    pulse_blkend();
    tick();
    pulse_blkend();
    chk("ovf_set", 32'(blk_ovf), 32'd1);
    wait_done(60);
    tick();
    chk("ovf_sticky", 32'(blk_ovf), 32'd1);
    begin_pass(16'd1, 1);
    chk("ovf_clr_on_start", 32'(blk_ovf), 32'd0);
    pulse_blkend();
    wait_done(40);
    tick();
    chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during tap (1,2), then a clean pass.
    begin_pass(16'd1, 1);
    pulse_blkend();
    wait_tap(2'd1, 2'd2, 20);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(tap_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_row_kr_kc", {26'd0, row, tap_kr, tap_kc}, 32'd0);
    chk("arst_done_ovf", {30'd0, done, blk_ovf}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);
    begin_pass(16'd1, 1);
    pulse_blkend();
    wait_done(40);
    chk("arst_clean_cycle", 32'(cyc - base), 32'd14);
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_router_ctrl.md
# data_router_ctrl

Command sequencer sitting directly upstream of the data router. It waits for the router's block-end pulse, then walks the kernel window row by row. For each row it issues a whole-row reload (RR) on the router's `bank/row/col/rpsel` command bus, then presents KSIZE column taps to the PE array over a valid/ready handshake. It counts blocks and signals completion of a layer pass.

## Interface
- `POY`, 3: router banks (output rows in parallel).
- `BUFH`, 3: router buffer rows; must be ≥ KSIZE.
- `BUFW`, 32: router buffer width in pixels.
- `KSIZE`, 3: kernel size; taps per row and rows per block.
- `STRIDE`, 1: horizontal stride; reported on `tap_base` arithmetic only.
- `NBLKW`, 16: width of block-count configuration.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse, begin a pass; ignored unless IDLE.
- `num_blk` in NBLKW: blocks per pass, sampled on `start`; 0 is treated as 1.
- `blkend` in 1: router pulse, one buffer block is ready.
- `bank` out 2: router bank select; always 0 (RR only).
- `row` out 2: router row select.
- `col` out 28: router column select; always 0.
- `rpsel` out 2: router op; always RR = 2'b00.
- `tap_valid` out 1: router data holds a valid tap.
- `tap_ready` in 1: PE array accepts the tap.
- `tap_kr` out 2: kernel row of the current tap.
- `tap_kc` out 2: kernel column of the current tap.
- `tap_base` out 28: column offset for PE x, `tap_kc`; PE x reads `col = tap_kc + STRIDE*x`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the last tap of the last block.
- `blk_ovf` out 1: sticky, `blkend` lost; cleared by `start` or reset.

## Operation
- States: IDLE, WAIT_BLK, LOAD, TAP.
- IDLE: `start` latches `num_blk` and clears `blk_cnt`, `kr`, `kc` and `blk_ovf`, then goes to WAIT_BLK.
- WAIT_BLK: `blkend` or a pending flag goes to LOAD and consumes the pending flag.
- LOAD (1 cycle): drive `row = kr`, `rpsel = RR`, then go to TAP with `kc = 0`.
- TAP: `tap_valid = 1`. On `tap_valid && tap_ready`:
  - If `kc < KSIZE-1`: `kc++`.
  - Else if `kr < KSIZE-1`: `kr++`, go to LOAD.
  - Else: `kr = 0`, `blk_cnt++`. If `blk_cnt + 1 == num_blk`, pulse `done` and go to IDLE; otherwise go to WAIT_BLK.
- Idle command: outside LOAD, `row` holds its last value and `rpsel = RR`. Re-reading the same row is idempotent in the router, so no invalid (NE) op is ever issued.
- `blkend` outside WAIT_BLK while busy: sets a 1-deep pending flag. If the flag is already set, set `blk_ovf`.
- `blkend` in the same cycle the last tap of a block is accepted: sets pending, so the next WAIT_BLK exits immediately.
- `blkend` in IDLE: ignored.
- `tap_base` = `tap_kc`. The STRIDE multiply is done per PE downstream; this block only guarantees `tap_kc + STRIDE*(BUFW-1)` fits in 28 bits.
- Reset values: state IDLE, `row` 0, `bank` 0, `col` 0, `rpsel` 0, `tap_valid` 0, `tap_kr` 0, `tap_kc` 0, `busy` 0, `done` 0, `blk_ovf` 0, pending 0, `blk_cnt` 0.
- Reset asserted mid-pass returns the block to IDLE immediately and drops all pending state.

## Timing
- All outputs are registered.
- The router samples the command at edge N (LOAD cycle) and its data is valid from cycle N+1. `tap_valid` first rises in cycle N+1.
- Per row: 1 LOAD cycle + KSIZE tap cycles at full throughput (KSIZE=3 gives 4 cycles).
- Per block with no stalls: KSIZE*(KSIZE+1) = 12 cycles from leaving WAIT_BLK.
- `blkend` to first LOAD: 1 cycle.
- `tap_ready` low: `tap_valid`, `tap_kr` and `tap_kc` hold stable and the router command is unchanged.
- `done` is asserted in the cycle after the final handshake; `busy` falls in the same cycle.

## Configuration
- `DATA_ROUTER_CTRL_STALL_CNT_EN` defined: adds output `stall_cnt` (16 bits). It counts cycles with `tap_valid && !tap_ready`, saturates at 16'hFFFF, and clears on `start` and on reset.
- Not defined: the port and the counter are absent.

## Test plan
- Single block, `num_blk=1`, `tap_ready=1`, KSIZE=3: `start`, then `blkend` at cycle 5 → LOADs with `row` 0, 1, 2 at cycles 6, 10, 14. Taps (kr,kc) run in order (0,0)…(2,2). `done` pulses at cycle 18, then `busy` = 0.
- Backpressure: hold `tap_ready=0` for 4 cycles at tap (1,1) → tap (1,1) stays stable, no LOAD is issued, and the sequence resumes unchanged.
- `num_blk=3`, with `blkend` arriving mid-TAP of block 0 → pending is set, and block 1 starts one cycle after WAIT_BLK is entered. After 27 handshakes, `done` pulses once.
- Two `blkend` pulses during one TAP phase → `blk_ovf` = 1 and stays set until the next `start`.
- Assert `rst` during tap (1,2) → all outputs at reset values the same cycle. A later `start` runs a clean pass.
- With `DATA_ROUTER_CTRL_STALL_CNT_EN`: 7 stall cycles → `stall_cnt` = 7. A following `start` clears it to 0.
